timed_window_tx: RTL and testbench
==================================

Name: timed_window_tx

Overview:
- Transmit side of the timer/data window protocol.
- Opens a receive window by presenting a one-cycle nonzero `timer` load value.
- Streams upstream words on `data` while the window is open and tracks the phase (1/2) the far-end receiver toggles through.
- Closes the window when its own countdown reaches zero.
- Sits between an upstream valid/ready word source and a window-timed receiver.

Parameters:
- WIDTH, 16, width of timer load, countdown and data words
- CNT_W, 8, width of the `words_sent` counter

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request to open a window; sampled in IDLE only
- win_len  input  WIDTH  window length in cycles; sampled with `start`
- in_data  input  WIDTH  upstream word
- in_valid  input  1  upstream word valid
- in_ready  output  1  word accepted this cycle when `in_valid && in_ready`
- timer  output  WIDTH  timer load to receiver; nonzero for exactly one cycle per window
- data  output  WIDTH  word to receiver; 0 when no word is sent
- phase  output  2  mirrored receiver phase: 0 idle, 1 or 2 in window
- busy  output  1  high from the OPEN state through the last SEND cycle
- done  output  1  one-cycle pulse on the cycle after the window closes
- words_sent  output  CNT_W  words accepted in the current/last window; saturating

Behaviour:
- Reset (async, rst=1): state=IDLE, rem=0, and all outputs are 0 (`timer`, `data`, `phase`, `busy`, `done`, `in_ready`, `words_sent`). Reset mid-window abandons the window; no `done` pulse.
- All outputs are registered except `in_ready`, which is combinational from state/rem.
- States: IDLE, OPEN, SEND, CLOSE.
- IDLE:
  - `in_ready`=0, `timer`=0, `data`=0, `phase`=0.
  - On `start` && `win_len`!=0: rem<=`win_len`, `words_sent`<=0, next=OPEN.
  - `start` with `win_len`==0 is ignored and stays in IDLE.
- OPEN (1 cycle):
  - `timer`=`win_len` as captured, `busy`=1, `data`=0, `in_ready`=0.
  - next=SEND with `phase`<=1.
- SEND:
  - `timer`=0, `busy`=1.
  - Each cycle rem<=rem-1 while rem!=0.
  - `in_ready`=1 iff rem!=0.
  - On accept, `data`<=`in_data` on the next cycle; otherwise `data`<=0.
  - An accepted nonzero word toggles `phase` 1<->2 on the next cycle. An accepted zero word is sent but does not toggle.
  - `words_sent` increments per accept and saturates at 2^CNT_W-1.
  - When rem==0: no accept, `data`<=0, next=CLOSE.
- CLOSE (1 cycle): `done`=1, `busy`=0, `phase`<=0, `data`=0; next=IDLE.
- `start` asserted in any state other than IDLE is ignored; it is not queued.
- rem never wraps below 0. A `win_len` of all-ones is legal and gives 2^WIDTH-1 SEND cycles with accepts.
- Latency: `start` at edge t -> `timer` nonzero during cycle t+1 -> first possible accept in cycle t+2.
- Window cycles with accepts = `win_len`. Total busy cycles = `win_len`+2 (OPEN + `win_len` accept cycles + final rem==0 SEND cycle).

Optional Feature:
- Macro: TIMED_WINDOW_GUARD_LAST_EN
- Defined: `in_ready`=0 additionally when rem==1. The last word of a window is never accepted, because the receiver sees a zero countdown on that cycle and ignores it. Accept cycles per window become `win_len`-1; `win_len`==1 yields zero accepts.
- Undefined: behaviour exactly as above.

Test Plan:
- Reset mid-SEND (`win_len`=10, after 3 accepts, assert `rst`) -> all outputs 0 immediately, no `done`. After release, `start` with `win_len`=2 works normally.
- `start`, `win_len`=4, `in_valid` held 1 with words 5,0,7,9 -> `timer`=4 for one cycle; `data` shows 5,0,7,9; `phase` goes 1,2,2,1,2; `words_sent`=4; `done` pulses once; `busy` high 6 cycles.
- `start` with `win_len`=0 -> stays IDLE; `timer`, `busy` and `in_ready` stay 0 for 5 cycles.
- `win_len`=3, `in_valid`=0 throughout -> `data`=0 throughout, `phase` stays 1, `words_sent`=0, `done` after the final SEND cycle.
- `start` pulsed again during SEND (`win_len`=5) -> ignored; exactly one `timer` pulse and one `done` pulse.
- CNT_W=2, `win_len`=6, `in_valid`=1 -> `words_sent` saturates at 3. With TIMED_WINDOW_GUARD_LAST_EN defined and `win_len`=4 -> exactly 3 accepts.

Source files
------------

// File: rtl/timed_window_tx.sv
// Window transmitter: one-cycle timer load, then streams upstream words until the countdown expires.
// Optional TIMED_WINDOW_GUARD_LAST_EN withholds in_ready on the final countdown cycle.
module timed_window_tx #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] win_len_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] timer_o,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       phase_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] words_sent_o
);

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        SEND,
        CLOSE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] timer_q, timer_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       phase_q, phase_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] words_q, words_d;

    logic rem_nz;
    logic accept;

    assign rem_nz = (rem_q != '0);

`ifdef TIMED_WINDOW_GUARD_LAST_EN
    // The receiver ignores the word sent while its countdown reads zero.
    assign in_ready_o = (state_q == SEND) && rem_nz && (rem_q != WIDTH'(1));
`else
    assign in_ready_o = (state_q == SEND) && rem_nz;
`endif

    assign accept = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        timer_d = '0;
        data_d  = '0;
        phase_d = phase_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        words_d = words_q;
        unique case (state_q)
            IDLE: begin
                if (start_i && (win_len_i != '0)) begin
                    state_d = OPEN;
                    rem_d   = win_len_i;
                    timer_d = win_len_i;
                    busy_d  = 1'b1;
                    words_d = '0;
                end
            end
            OPEN: begin
                state_d = SEND;
                phase_d = 2'd1;
            end
            SEND: begin
                if (rem_nz) begin
                    rem_d = rem_q - WIDTH'(1);
                    if (accept) begin
                        data_d = in_data_i;
                        // Zero words carry no edge for the receiver to follow.
                        if (in_data_i != '0) begin
                            phase_d = (phase_q == 2'd1) ? 2'd2 : 2'd1;
                        end
                        if (words_q != '1) begin
                            words_d = words_q + CNT_W'(1);
                        end
                    end
                end else begin
                    state_d = CLOSE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            CLOSE: begin
                state_d = IDLE;
                phase_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            timer_q <= '0;
            data_q  <= '0;
            phase_q <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            words_q <= words_d;
        end
    end

    assign timer_o      = timer_q;
    assign data_o       = data_q;
    assign phase_o      = phase_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign words_sent_o = words_q;

endmodule

// File: tb/tb_timed_window_tx.sv
// Directed bench for timed_window_tx: vector table for a full window plus corner sequences.
module tb_timed_window_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] win_len_i = '0;
    logic [15:0] in_data_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [15:0] timer_o, data_o;
    logic [1:0]  phase_o;
    logic        busy_o, done_o;
    logic [7:0]  words_sent_o;

    logic        rdy2, busy2, done2;
    logic [15:0] timer2, data2;
    logic [1:0]  phase2;
    logic [1:0]  words2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    timed_window_tx #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .win_len_i(win_len_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .timer_o(timer_o), .data_o(data_o), .phase_o(phase_o), .busy_o(busy_o),
        .done_o(done_o), .words_sent_o(words_sent_o)
    );

    timed_window_tx #(.WIDTH(16), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start_i(start_i), .win_len_i(win_len_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(rdy2),
        .timer_o(timer2), .data_o(data2), .phase_o(phase2), .busy_o(busy2),
        .done_o(done2), .words_sent_o(words2)
    );

    typedef struct {
        logic        st;
        logic [15:0] wl;
        logic        iv;
        logic [15:0] id;
        logic [15:0] e_timer;
        logic [15:0] e_data;
        logic [1:0]  e_phase;
        logic        cp;
        logic        e_busy;
        logic        e_done;
        logic        e_rdy;
        logic [7:0]  e_words;
    } vec_t;

    vec_t tbl[9];

    function automatic vec_t mk(logic st, logic [15:0] wl, logic iv, logic [15:0] id,
                                logic [15:0] et, logic [15:0] ed, logic [1:0] ep,
                                logic cp, logic eb, logic edn, logic er, logic [7:0] ew);
        vec_t v;
        v.st = st; v.wl = wl; v.iv = iv; v.id = id;
        v.e_timer = et; v.e_data = ed; v.e_phase = ep; v.cp = cp;
        v.e_busy = eb; v.e_done = edn; v.e_rdy = er; v.e_words = ew;
        return v;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(logic st, logic [15:0] wl, logic iv, logic [15:0] id);
        start_i = st; win_len_i = wl; in_valid_i = iv; in_data_i = id;
    endtask

    int done_at, tpulse, dpulse, bcyc;

    initial begin
        // start, wl, iv, id | timer, data, phase, chkph, busy, done, rdy, words
        tbl[0] = mk(1, 4, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0);
        tbl[1] = mk(0, 0, 1, 5,  4, 0, 0, 1, 1, 0, 0, 0);
        tbl[2] = mk(0, 0, 1, 5,  0, 0, 1, 1, 1, 0, 1, 0);
        tbl[3] = mk(0, 0, 1, 0,  0, 5, 2, 1, 1, 0, 1, 1);
        tbl[4] = mk(0, 0, 1, 7,  0, 0, 2, 1, 1, 0, 1, 2);
`ifdef TIMED_WINDOW_GUARD_LAST_EN
        tbl[5] = mk(0, 0, 1, 9,  0, 7, 1, 1, 1, 0, 0, 3);
        tbl[6] = mk(0, 0, 1, 11, 0, 0, 1, 1, 1, 0, 0, 3);
        tbl[7] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 3);
        tbl[8] = mk(0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 3);
`else
        tbl[5] = mk(0, 0, 1, 9,  0, 7, 1, 1, 1, 0, 1, 3);
        tbl[6] = mk(0, 0, 1, 11, 0, 9, 2, 1, 1, 0, 0, 4);
        tbl[7] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 4);
        tbl[8] = mk(0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 4);
`endif

        // Reset state
        #12;
        chk("rst_outputs", {timer_o, data_o, phase_o, busy_o, done_o, in_ready_o, words_sent_o}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Full window from the vector table
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("tbl%0d_timer", i), timer_o, tbl[i].e_timer);
            chk($sformatf("tbl%0d_data", i), data_o, tbl[i].e_data);
            if (tbl[i].cp) chk($sformatf("tbl%0d_phase", i), phase_o, tbl[i].e_phase);
            chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].e_busy);
            chk($sformatf("tbl%0d_done", i), done_o, tbl[i].e_done);
            chk($sformatf("tbl%0d_ready", i), in_ready_o, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_words", i), words_sent_o, tbl[i].e_words);
            drive(tbl[i].st, tbl[i].wl, tbl[i].iv, tbl[i].id);
        end

        // start with win_len 0 is ignored
        @(negedge clk);
        drive(1, 0, 1, 3);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            chk($sformatf("zero_len_c%0d", k), {timer_o, busy_o, in_ready_o}, 0);
        end

        // win_len 3 with no valid words
        drive(1, 3, 0, 0);
        done_at = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (k == 1) chk("novalid_timer", timer_o, 3);
            if (k >= 2 && k <= 5) begin
                chk($sformatf("novalid_data_c%0d", k), data_o, 0);
                chk($sformatf("novalid_phase_c%0d", k), phase_o, 1);
            end
            if (done_o && done_at < 0) done_at = k;
        end
        chk("novalid_done_at", done_at, 6);
        chk("novalid_words", words_sent_o, 0);

        // start re-pulsed during SEND is ignored
        drive(1, 5, 0, 0);
        tpulse = 0; dpulse = 0; bcyc = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start_i = (k == 3 || k == 5);
            win_len_i = 16'd9;
            if (timer_o != 0) tpulse++;
            if (done_o) dpulse++;
            if (busy_o) bcyc++;
        end
        start_i = 1'b0;
        chk("restart_timer_pulses", tpulse, 1);
        chk("restart_done_pulses", dpulse, 1);
        chk("restart_busy_cycles", bcyc, 7);

        // Saturation of the 2-bit counter, win_len 6
        drive(1, 6, 1, 3);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        chk("sat_words_cnt2", words2, 3);
`ifdef TIMED_WINDOW_GUARD_LAST_EN
        chk("sat_words_cnt8", words_sent_o, 5);
`else
        chk("sat_words_cnt8", words_sent_o, 6);
`endif

        // Reset mid-SEND after three accepts
        drive(1, 10, 1, 1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        chk("midrst_words_before", words_sent_o, 3);
        #2 rst = 1'b1;
        #1;
        chk("midrst_outputs", {timer_o, data_o, phase_o, busy_o, done_o, in_ready_o, words_sent_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        in_valid_i = 1'b0;
        dpulse = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (done_o) dpulse++;
        end
        chk("midrst_no_done", dpulse, 0);
        drive(1, 2, 1, 8);
        done_at = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (k == 1) chk("after_rst_timer", timer_o, 2);
            if (done_o && done_at < 0) done_at = k;
        end
        chk("after_rst_done_at", done_at, 5);
`ifdef TIMED_WINDOW_GUARD_LAST_EN
        chk("after_rst_words", words_sent_o, 1);
`else
        chk("after_rst_words", words_sent_o, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
